// File: rtl/detonator_pkg.sv
// Shared definitions for the detonator session controller: state encoding,
// keypad idle pattern and keypad decode helpers.
package detonator_pkg;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_ARMED   = 3'd1;
  localparam logic [2:0] ST_ENTRY   = 3'd2;
  localparam logic [2:0] ST_VERIFY  = 3'd3;
  localparam logic [2:0] ST_GRANTED = 3'd4;
  localparam logic [2:0] ST_FIRING  = 3'd5;
  localparam logic [2:0] ST_ERROR   = 3'd6;
  localparam logic [2:0] ST_LOCKOUT = 3'd7;

  localparam logic [9:0] ALL_UP = 10'h3FF;

  function automatic logic is_onehot(input logic [9:0] vec);
    logic [3:0] ones;
    ones = '0;
    for (int i = 0; i < 10; i++) ones = ones + {3'd0, vec[i]};
    return ones == 4'd1;
  endfunction

  function automatic logic [3:0] onehot_to_bcd(input logic [9:0] onehot);
    logic [3:0] bcd;
    bcd = '0;
    for (int i = 0; i < 10; i++) begin
      if (onehot[i]) bcd = 4'(i);
    end
    return bcd;
  endfunction

endpackage

// File: rtl/detonator_session_ctrl_keypad_edge_decoder.sv
// Turns raw active-low keypad levels into one digit event per clean press:
// idle (all keys up) followed by exactly one key down.
module keypad_edge_decoder
  import detonator_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] key_n,
  output logic [3:0] digit,
  output logic       digit_vld
);

  logic [9:0] key_p0;
  logic [9:0] key_p1;
  logic       press;

  // A press only counts when the previous sample was fully idle, so holds
  // never repeat and multi-key chords must return to idle before re-arming.
  assign press = (key_p1 == ALL_UP) && is_onehot(~key_p0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      key_p0    <= ALL_UP;
      key_p1    <= ALL_UP;
      digit     <= '0;
      digit_vld <= 1'b0;
    end else begin
      key_p0    <= key_n;
      key_p1    <= key_p0;
      digit_vld <= press;
      if (press) digit <= onehot_to_bcd(~key_p0);
    end
  end

endmodule

// File: rtl/detonator_session_ctrl.sv
// Detonator session sequencer: code entry, verify, retry lockout and fire window.
// Optional key click on the buzzer when SESSION_KEY_BEEP_EN is defined.
module detonator_session_ctrl
  import detonator_pkg::*;
#(
  parameter int CODE_LEN      = 4,
  parameter int MAX_TRIES     = 3,
  parameter int ENTRY_TIMEOUT = 1000,
  parameter int LOCKOUT_CYC   = 5000,
  parameter int FIRE_WINDOW   = 2000,
  parameter int CNT_W         = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [9:0]            key_n,
  input  logic                  ready,
  input  logic                  wait_t,
  input  logic                  sure,
  input  logic                  fire,
  input  logic                  setup,
  input  logic [4*CODE_LEN-1:0] code_ref,
  output logic [3:0]            digit,
  output logic                  digit_vld,
  output logic [2:0]            state_o,
  output logic [3:0]            tries_left,
  output logic                  lt,
  output logic                  bt,
  output logic                  rt,
  output logic                  lb
);

  localparam int               CODE_W     = 4 * CODE_LEN;
  localparam logic [3:0]       CODE_LEN_C = 4'(CODE_LEN);
  localparam logic [3:0]       MAX_T      = 4'(MAX_TRIES);
  localparam logic [CNT_W-1:0] ENTRY_LIM  = CNT_W'(ENTRY_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] FIRE_LIM   = CNT_W'(FIRE_WINDOW - 1);
  localparam logic [CNT_W-1:0] LOCK_LIM   = CNT_W'(LOCKOUT_CYC - 1);

  logic [2:0]        state, state_next;
  logic [CODE_W-1:0] code, code_next;
  logic [3:0]        count, count_next;
  logic [3:0]        fail_cnt, fail_next;
  logic [CNT_W-1:0]  timer, timer_next;
  logic              timer_restart;
  logic              lt_next, bt_next, rt_next, lb_next;
  logic              click;

  keypad_edge_decoder u_keys (
    .clk       (clk),
    .rst       (rst),
    .key_n     (key_n),
    .digit     (digit),
    .digit_vld (digit_vld)
  );

  assign state_o    = state;
  assign tries_left = MAX_T - fail_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      code     <= '0;
      count    <= '0;
      fail_cnt <= '0;
      timer    <= '0;
      lt       <= 1'b0;
      bt       <= 1'b0;
      rt       <= 1'b0;
      lb       <= 1'b0;
    end else begin
      state    <= state_next;
      code     <= code_next;
      count    <= count_next;
      fail_cnt <= fail_next;
      timer    <= timer_next;
      lt       <= lt_next;
      bt       <= bt_next;
      rt       <= rt_next;
      lb       <= lb_next;
    end
  end

  // Each state's branches follow fire > sure > wait_t > digit precedence.
  always_comb begin
    state_next    = state;
    code_next     = code;
    count_next    = count;
    fail_next     = fail_cnt;
    timer_restart = 1'b0;
    case (state)
      ST_IDLE: begin
        if (fire)       state_next = ST_ERROR;
        else if (ready) state_next = ST_ARMED;
      end
      ST_ARMED: begin
        if (fire || sure) state_next = ST_ERROR;
        else if (wait_t)  state_next = ST_IDLE;
        else if (digit_vld) begin
          state_next = ST_ENTRY;
          code_next  = CODE_W'(digit);
          count_next = 4'd1;
        end
      end
      ST_ENTRY: begin
        if (sure) begin
          state_next = (count == CODE_LEN_C) ? ST_VERIFY : ST_ERROR;
        end else if (wait_t) begin
          state_next = ST_IDLE;
        end else if (digit_vld) begin
          if (count == CODE_LEN_C) begin
            state_next = ST_ERROR;
          end else begin
            code_next     = CODE_W'({code, digit});
            count_next    = count + 4'd1;
            timer_restart = 1'b1;
          end
        end else if (timer == ENTRY_LIM) begin
          state_next = ST_ERROR;
        end
      end
      ST_VERIFY: begin
        if (code == code_ref) begin
          state_next = ST_GRANTED;
          fail_next  = '0;
        end else begin
          state_next = ST_ERROR;
          fail_next  = (fail_cnt == MAX_T) ? fail_cnt : fail_cnt + 4'd1;
        end
      end
      ST_GRANTED: begin
        if (fire)                   state_next = ST_FIRING;
        else if (timer == FIRE_LIM) state_next = ST_IDLE;
      end
      ST_FIRING: state_next = ST_IDLE;
      ST_ERROR: begin
        if (fail_cnt == MAX_T) state_next = ST_LOCKOUT;
        else if (setup)        state_next = ST_IDLE;
      end
      ST_LOCKOUT: begin
        if (timer == LOCK_LIM) begin
          state_next = ST_IDLE;
          fail_next  = '0;
        end
      end
      default: state_next = ST_IDLE;
    endcase

    if ((state_next != state) && ((state_next == ST_IDLE) || (state_next == ST_ERROR))) begin
      code_next  = '0;
      count_next = '0;
    end

    timer_next = ((state_next != state) || timer_restart) ? '0 : timer + 1'b1;
  end

`ifdef SESSION_KEY_BEEP_EN
  logic [2:0] click_cnt, click_next;

  always_comb begin
    if (digit_vld)              click_next = 3'd4;
    else if (click_cnt != 3'd0) click_next = click_cnt - 3'd1;
    else                        click_next = 3'd0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) click_cnt <= '0;
    else     click_cnt <= click_next;
  end

  assign click = (click_next != 3'd0);
`else
  assign click = 1'b0;
`endif

  // Lamps are decoded from the next state so the registered lamps line up
  // with the registered state.
  always_comb begin
    lt_next = (state_next == ST_GRANTED);
    bt_next = (state_next == ST_FIRING);
    rt_next = (state_next == ST_ERROR) || (state_next == ST_LOCKOUT);
    lb_next = rt_next || click;
  end

endmodule

// File: tb/tb_detonator_session_ctrl.sv
// Self-checking bench for detonator_session_ctrl: directed scenarios plus
// randomized sessions checked against a session-level outcome model.
module tb_detonator_session_ctrl;

  localparam int CODE_LEN      = 4;
  localparam int MAX_TRIES     = 3;
  localparam int ENTRY_TIMEOUT = 1000;
  localparam int LOCKOUT_CYC   = 5000;
  localparam int FIRE_WINDOW   = 2000;
  localparam int CNT_W         = 16;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_ARMED   = 3'd1;
  localparam logic [2:0] S_ENTRY   = 3'd2;
  localparam logic [2:0] S_VERIFY  = 3'd3;
  localparam logic [2:0] S_GRANTED = 3'd4;
  localparam logic [2:0] S_FIRING  = 3'd5;
  localparam logic [2:0] S_ERROR   = 3'd6;
  localparam logic [2:0] S_LOCKOUT = 3'd7;

  localparam logic [9:0] KEYS_UP = 10'h3FF;

  localparam int P_READY = 0;
  localparam int P_SURE  = 1;
  localparam int P_FIRE  = 2;
  localparam int P_SETUP = 3;
  localparam int P_WAIT  = 4;

`ifdef SESSION_KEY_BEEP_EN
  localparam int CLICK_CYC = 4;
`else
  localparam int CLICK_CYC = 0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [9:0]  key_n = KEYS_UP;
  logic        ready = 1'b0, wait_t = 1'b0, sure = 1'b0, fire = 1'b0, setup = 1'b0;
  logic [15:0] code_ref = '0;
  logic [3:0]  digit;
  logic        digit_vld;
  logic [2:0]  state_o;
  logic [3:0]  tries_left;
  logic        lt, bt, rt, lb;

  int tests_run    = 0;
  int tests_failed = 0;
  int vld_cnt      = 0;
  int model_fails  = 0;

  detonator_session_ctrl #(
    .CODE_LEN(CODE_LEN), .MAX_TRIES(MAX_TRIES), .ENTRY_TIMEOUT(ENTRY_TIMEOUT),
    .LOCKOUT_CYC(LOCKOUT_CYC), .FIRE_WINDOW(FIRE_WINDOW), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .key_n(key_n), .ready(ready), .wait_t(wait_t),
    .sure(sure), .fire(fire), .setup(setup), .code_ref(code_ref),
    .digit(digit), .digit_vld(digit_vld), .state_o(state_o),
    .tries_left(tries_left), .lt(lt), .bt(bt), .rt(rt), .lb(lb)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (digit_vld === 1'b1) vld_cnt++;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached, tests_run=%0d", tests_run);
    $fatal(1);
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse(input int sel);
    case (sel)
      P_READY: ready  = 1'b1;
      P_SURE:  sure   = 1'b1;
      P_FIRE:  fire   = 1'b1;
      P_SETUP: setup  = 1'b1;
      default: wait_t = 1'b1;
    endcase
    step(1);
    ready = 1'b0; sure = 1'b0; fire = 1'b0; setup = 1'b0; wait_t = 1'b0;
  endtask

  task automatic press_key(input int d);
    key_n = KEYS_UP ^ (10'b1 << d);
    step(3);
    key_n = KEYS_UP;
    step(3);
  endtask

  task automatic enter_digits(input logic [31:0] code, input int n);
    for (int i = 0; i < n; i++) press_key(int'((code >> (4 * (n - 1 - i))) & 32'hF));
  endtask

  function automatic logic [15:0] random_code();
    logic [15:0] c;
    c = '0;
    for (int i = 0; i < CODE_LEN; i++) c = {c[11:0], 4'($urandom_range(0, 9))};
    return c;
  endfunction

  // Drives a correct code and leaves the controller in GRANTED.
  task automatic reach_granted();
    pulse(P_READY);
    enter_digits({16'd0, code_ref}, CODE_LEN);
    pulse(P_SURE);
    step(1);
  endtask

  task automatic wait_lockout_exit(output int n);
    n = 0;
    while (state_o == S_LOCKOUT && n < LOCKOUT_CYC + 50) begin
      n++;
      step(1);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(2);
    tests_run++;
    if (state_o !== S_IDLE || digit !== 4'd0 || digit_vld !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_state: state=%0d digit=%0d vld=%0b, want 0/0/0", state_o, digit, digit_vld);
    end
    tests_run++;
    if ({lt, bt, rt, lb} !== 4'b0000 || tries_left !== 4'(MAX_TRIES)) begin
      tests_failed++;
      $display("FAIL reset_outputs: lamps=%b tries=%0d, want 0000/%0d", {lt, bt, rt, lb}, tries_left, MAX_TRIES);
    end
    rst = 1'b0;
    step(2);
  endtask

  task automatic test_grant_fire();
    int base;
    code_ref = 16'h2580;
    pulse(P_READY);
    tests_run++;
    if (state_o !== S_ARMED) begin
      tests_failed++;
      $display("FAIL arm: state=%0d want %0d", state_o, S_ARMED);
    end
    base = vld_cnt;
    enter_digits(32'h2580, 4);
    tests_run++;
    if (state_o !== S_ENTRY || vld_cnt - base !== 4 || digit !== 4'd0) begin
      tests_failed++;
      $display("FAIL entry_2580: state=%0d vld=%0d digit=%0d, want %0d/4/0", state_o, vld_cnt - base, digit, S_ENTRY);
    end
    pulse(P_SURE);
    tests_run++;
    if (state_o !== S_VERIFY) begin
      tests_failed++;
      $display("FAIL verify: state=%0d want %0d", state_o, S_VERIFY);
    end
    step(1);
    tests_run++;
    if (state_o !== S_GRANTED || lt !== 1'b1 || tries_left !== 4'd3) begin
      tests_failed++;
      $display("FAIL granted: state=%0d lt=%0b tries=%0d, want %0d/1/3", state_o, lt, tries_left, S_GRANTED);
    end
    pulse(P_FIRE);
    tests_run++;
    if (state_o !== S_FIRING || bt !== 1'b1 || lt !== 1'b0) begin
      tests_failed++;
      $display("FAIL firing: state=%0d bt=%0b lt=%0b, want %0d/1/0", state_o, bt, lt, S_FIRING);
    end
    step(1);
    tests_run++;
    if (state_o !== S_IDLE || bt !== 1'b0) begin
      tests_failed++;
      $display("FAIL after_fire: state=%0d bt=%0b, want %0d/0", state_o, bt, S_IDLE);
    end
  endtask

  task automatic test_lockout();
    int n;
    code_ref = 16'h2580;
    for (int t = 1; t <= MAX_TRIES; t++) begin
      pulse(P_READY);
      enter_digits(32'h1234, 4);
      pulse(P_SURE);
      step(1);
      if (model_fails < MAX_TRIES) model_fails++;
      tests_run++;
      if (state_o !== S_ERROR || tries_left !== 4'(MAX_TRIES - model_fails)) begin
        tests_failed++;
        $display("FAIL wrong_code_%0d: state=%0d tries=%0d, want %0d/%0d", t, state_o, tries_left, S_ERROR, MAX_TRIES - model_fails);
      end
      if (t < MAX_TRIES) pulse(P_SETUP);
    end
    step(1);
    tests_run++;
    if (state_o !== S_LOCKOUT || rt !== 1'b1 || lb !== 1'b1) begin
      tests_failed++;
      $display("FAIL lockout_entry: state=%0d rt=%0b lb=%0b, want %0d/1/1", state_o, rt, lb, S_LOCKOUT);
    end
    setup = 1'b1;
    ready = 1'b1;
    wait_lockout_exit(n);
    setup = 1'b0;
    ready = 1'b0;
    model_fails = 0;
    tests_run++;
    if (n !== LOCKOUT_CYC || state_o !== S_IDLE || tries_left !== 4'(MAX_TRIES)) begin
      tests_failed++;
      $display("FAIL lockout_len: cycles=%0d state=%0d tries=%0d, want %0d/%0d/%0d", n, state_o, tries_left, LOCKOUT_CYC, S_IDLE, MAX_TRIES);
    end
  endtask

  task automatic test_entry_timeout();
    int n;
    pulse(P_READY);
    press_key(3);
    press_key(7);
    n = 0;
    while (state_o == S_ENTRY && n < ENTRY_TIMEOUT + 20) begin
      n++;
      step(1);
    end
    tests_run++;
    if (state_o !== S_ERROR || n < ENTRY_TIMEOUT - 8 || n > ENTRY_TIMEOUT + 2) begin
      tests_failed++;
      $display("FAIL entry_timeout: state=%0d idle_cycles=%0d, want %0d near %0d", state_o, n, S_ERROR, ENTRY_TIMEOUT - 3);
    end
    tests_run++;
    if (rt !== 1'b1 || lb !== 1'b1 || tries_left !== 4'(MAX_TRIES - model_fails)) begin
      tests_failed++;
      $display("FAIL timeout_lamps: rt=%0b lb=%0b tries=%0d, want 1/1/%0d", rt, lb, tries_left, MAX_TRIES - model_fails);
    end
    pulse(P_SETUP);
    tests_run++;
    if (state_o !== S_IDLE || rt !== 1'b0) begin
      tests_failed++;
      $display("FAIL timeout_setup: state=%0d rt=%0b, want %0d/0", state_o, rt, S_IDLE);
    end
  endtask

  task automatic test_key_hold();
    int base;
    base = vld_cnt;
    key_n = KEYS_UP ^ (10'b1 << 5);
    step(50);
    key_n = KEYS_UP;
    step(3);
    tests_run++;
    if (vld_cnt - base !== 1 || digit !== 4'd5 || state_o !== S_IDLE) begin
      tests_failed++;
      $display("FAIL key_hold: pulses=%0d digit=%0d state=%0d, want 1/5/%0d", vld_cnt - base, digit, state_o, S_IDLE);
    end
    base = vld_cnt;
    key_n = 10'h3F6;
    step(10);
    key_n = 10'h3F7;
    step(10);
    key_n = KEYS_UP;
    step(3);
    tests_run++;
    if (vld_cnt - base !== 0 || digit !== 4'd5) begin
      tests_failed++;
      $display("FAIL multi_key: pulses=%0d digit=%0d, want 0/5", vld_cnt - base, digit);
    end
  endtask

  task automatic test_fire_window();
    int n;
    code_ref = random_code();
    reach_granted();
    tests_run++;
    if (state_o !== S_GRANTED) begin
      tests_failed++;
      $display("FAIL window_grant: state=%0d want %0d", state_o, S_GRANTED);
    end
    sure = 1'b1;
    wait_t = 1'b1;
    n = 0;
    while (state_o == S_GRANTED && n < FIRE_WINDOW + 50) begin
      n++;
      step(1);
    end
    sure = 1'b0;
    wait_t = 1'b0;
    tests_run++;
    if (n !== FIRE_WINDOW || state_o !== S_IDLE || lt !== 1'b0) begin
      tests_failed++;
      $display("FAIL fire_window: cycles=%0d state=%0d lt=%0b, want %0d/%0d/0", n, state_o, lt, FIRE_WINDOW, S_IDLE);
    end
  endtask

  task automatic test_sure_wait_same_cycle();
    pulse(P_READY);
    press_key(4);
    press_key(9);
    sure = 1'b1;
    wait_t = 1'b1;
    step(1);
    sure = 1'b0;
    wait_t = 1'b0;
    tests_run++;
    if (state_o !== S_ERROR || tries_left !== 4'(MAX_TRIES - model_fails)) begin
      tests_failed++;
      $display("FAIL sure_wait: state=%0d tries=%0d, want %0d/%0d", state_o, tries_left, S_ERROR, MAX_TRIES - model_fails);
    end
    pulse(P_SETUP);
  endtask

  task automatic test_random_sessions();
    logic [15:0] entered;
    logic [2:0]  want_state;
    int mode, k, n, nd;
    for (int s = 0; s < 24; s++) begin
      code_ref = random_code();
      mode = $urandom_range(0, 9);
      entered = code_ref;
      pulse(P_READY);
      if (mode == 6 || mode == 7) begin
        k = $urandom_range(0, CODE_LEN - 1);
        entered[4*k +: 4] = 4'((int'(code_ref[4*k +: 4]) + 1) % 10);
      end
      if (mode == 8) begin
        nd = $urandom_range(1, CODE_LEN - 1);
        enter_digits({16'd0, entered} >> (4 * (CODE_LEN - nd)), nd);
        pulse(P_SURE);
      end else if (mode == 9) begin
        enter_digits({16'd0, entered}, CODE_LEN);
        press_key($urandom_range(0, 9));
      end else begin
        enter_digits({16'd0, entered}, CODE_LEN);
        pulse(P_SURE);
        step(1);
      end
      if (mode < 6) begin
        want_state = S_GRANTED;
        model_fails = 0;
      end else begin
        want_state = S_ERROR;
        if ((mode == 6 || mode == 7) && model_fails < MAX_TRIES) model_fails++;
      end
      tests_run++;
      if (state_o !== want_state || tries_left !== 4'(MAX_TRIES - model_fails)) begin
        tests_failed++;
        $display("FAIL session_%0d mode %0d ref %h: state=%0d tries=%0d, want %0d/%0d", s, mode, code_ref, state_o, tries_left, want_state, MAX_TRIES - model_fails);
      end
      if (want_state == S_GRANTED) begin
        pulse(P_FIRE);
        step(1);
      end else if (model_fails == MAX_TRIES) begin
        step(1);
        wait_lockout_exit(n);
        model_fails = 0;
      end else begin
        pulse(P_SETUP);
      end
      tests_run++;
      if (state_o !== S_IDLE) begin
        tests_failed++;
        $display("FAIL session_%0d_exit: state=%0d want %0d", s, state_o, S_IDLE);
      end
    end
  endtask

  task automatic test_reset_midop();
    code_ref = 16'h9317;
    pulse(P_READY);
    enter_digits(32'h9318, 4);
    pulse(P_SURE);
    step(1);
    #2 rst = 1'b1;
    #1;
    tests_run++;
    if (state_o !== S_IDLE || tries_left !== 4'(MAX_TRIES) || rt !== 1'b0 || lb !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_in_error: state=%0d tries=%0d rt=%0b lb=%0b, want %0d/%0d/0/0", state_o, tries_left, rt, lb, S_IDLE, MAX_TRIES);
    end
    step(1);
    rst = 1'b0;
    model_fails = 0;
    step(1);
    reach_granted();
    #2 rst = 1'b1;
    #1;
    tests_run++;
    if (state_o !== S_IDLE || {lt, bt, rt, lb} !== 4'b0000 || digit !== 4'd0 || digit_vld !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_in_granted: state=%0d lamps=%b digit=%0d vld=%0b, want %0d/0000/0/0", state_o, {lt, bt, rt, lb}, digit, digit_vld, S_IDLE);
    end
    step(1);
    rst = 1'b0;
    step(1);
  endtask

  task automatic test_key_click();
    int n;
    n = 0;
    key_n = KEYS_UP ^ (10'b1 << 6);
    for (int i = 0; i < 10; i++) begin
      step(1);
      if (lb === 1'b1) n++;
    end
    key_n = KEYS_UP;
    for (int i = 0; i < 4; i++) begin
      step(1);
      if (lb === 1'b1) n++;
    end
    tests_run++;
    if (n !== CLICK_CYC || state_o !== S_IDLE) begin
      tests_failed++;
      $display("FAIL key_click: lb_cycles=%0d state=%0d, want %0d/%0d", n, state_o, CLICK_CYC, S_IDLE);
    end
  endtask

  initial begin
    test_reset();
    test_grant_fire();
    test_lockout();
    test_entry_timeout();
    test_key_hold();
    test_fire_window();
    test_sure_wait_same_cycle();
    test_random_sessions();
    test_reset_midop();
    test_key_click();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
